// File: rtl/eth_tx_pkt_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_pkt_buf_if
// Description : Application write stream and TX-pipe replay/announce signals
//               for eth_tx_pkt_buf. slave = the buffer, master = its peers.
// Revision    : 1.0  initial release
// ============================================================================
interface eth_tx_pkt_buf_if #(
   parameter int DATA_W    = 16,
   parameter int KEEP_W    = DATA_W / 8,
   parameter int LEN_W     = $clog2(KEEP_W + 1),
   parameter int PKT_LEN_W = 16,
   parameter int UDP_CS_W  = 16
);
   logic                 wr_valid_i;
   logic [DATA_W-1:0]    wr_data_i;
   logic [LEN_W-1:0]     wr_len_i;
   logic                 wr_last_i;
   logic                 wr_abort_i;
   logic                 wr_ready_o;
   logic                 drop_o;
   logic                 app_early_v_o;
   logic [PKT_LEN_W-1:0] app_pkt_len_o;
   logic [UDP_CS_W-1:0]  app_cs_o;
   logic                 app_cancel_o;
   logic                 app_ready_v_i;
   logic                 app_valid_o;
   logic [DATA_W-1:0]    app_data_o;
   logic [LEN_W-1:0]     app_len_o;

   modport slave (
      input  wr_valid_i, wr_data_i, wr_len_i, wr_last_i, wr_abort_i, app_ready_v_i,
      output wr_ready_o, drop_o, app_early_v_o, app_pkt_len_o, app_cs_o,
             app_cancel_o, app_valid_o, app_data_o, app_len_o
   );

   modport master (
      output wr_valid_i, wr_data_i, wr_len_i, wr_last_i, wr_abort_i, app_ready_v_i,
      input  wr_ready_o, drop_o, app_early_v_o, app_pkt_len_o, app_cs_o,
             app_cancel_o, app_valid_o, app_data_o, app_len_o
   );
endinterface
`default_nettype wire

// File: rtl/eth_tx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_pkt_buf
// Description : Single-packet store-and-forward buffer ahead of the Ethernet
//               TX pipe. Accumulates payload length and one's-complement
//               checksum while filling, announces the packet, then replays.
//               Macro ETH_TX_PKT_BUF_CS_EN builds the checksum logic; without
//               it app_cs_o is tied to zero.
// Revision    : 1.0  initial release
// ============================================================================
module eth_tx_pkt_buf #(
   parameter int DATA_W    = 16,
   parameter int KEEP_W    = DATA_W / 8,
   parameter int LEN_W     = $clog2(KEEP_W + 1),
   parameter int PKT_LEN_W = 16,
   parameter int UDP_CS_W  = 16,
   parameter int DEPTH     = 1024,
   parameter int ADDR_W    = $clog2(DEPTH)
) (
   input  wire logic       clk,
   input  wire logic       reset,
   eth_tx_pkt_buf_if.slave bus
);
   localparam int PTR_W = ADDR_W + 1;
   localparam logic [1:0] c_FILL  = 2'd0;
   localparam logic [1:0] c_DROP  = 2'd1;
   localparam logic [1:0] c_EARLY = 2'd2;
   localparam logic [1:0] c_SEND  = 2'd3;
   localparam logic [PTR_W-1:0] c_DEPTH = PTR_W'(DEPTH);

   logic [1:0]           r_state, w_next_state;
   logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr, r_beat_cnt;
   logic [PKT_LEN_W-1:0] r_len_acc, r_pkt_len, w_len_next;
   logic [UDP_CS_W-1:0]  w_pkt_cs;
   logic [DATA_W-1:0]    r_mem [DEPTH];
   logic [LEN_W-1:0]     r_len_mem [DEPTH];
   logic [DATA_W-1:0]    r_rd_data;
   logic [LEN_W-1:0]     r_rd_len;
   logic [ADDR_W-1:0]    w_rd_addr;
   logic                 w_wr_fire, w_full, w_last_rd, w_clear, w_store, w_busy;

   assign w_wr_fire  = bus.wr_valid_i & ((r_state == c_FILL) | (r_state == c_DROP));
   assign w_full     = (r_wr_ptr == c_DEPTH);
   assign w_len_next = r_len_acc + PKT_LEN_W'(bus.wr_len_i);
   assign w_last_rd  = (r_rd_ptr == r_beat_cnt - PTR_W'(1));
   assign w_busy     = (r_state == c_EARLY) | (r_state == c_SEND);

   // Every path back to FILL wipes pointers and accumulators.
   assign w_clear = bus.wr_abort_i
                  | ((r_state == c_DROP) & w_wr_fire & bus.wr_last_i)
                  | ((r_state == c_FILL) & w_wr_fire & bus.wr_last_i
                     & (w_full | (w_len_next == '0)))
                  | ((r_state == c_SEND) & bus.app_ready_v_i & w_last_rd);
   assign w_store = (r_state == c_FILL) & w_wr_fire & ~w_clear;

   // Prefetch the next beat so back-to-back ready streams without bubbles.
   assign w_rd_addr = ((r_state == c_SEND) & bus.app_ready_v_i & ~w_last_rd)
                    ? ADDR_W'(r_rd_ptr + PTR_W'(1)) : ADDR_W'(r_rd_ptr);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_FILL;
      else       r_state <= w_next_state;
   end

   // Next-state logic; abort wins over a same-cycle beat.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_FILL: begin
            if (bus.wr_abort_i)
               w_next_state = c_FILL;
            else if (w_wr_fire && bus.wr_last_i)
               w_next_state = (w_full || (w_len_next == '0)) ? c_FILL : c_EARLY;
            else if (w_wr_fire && w_full)
               w_next_state = c_DROP;
         end
         c_DROP:  if (bus.wr_abort_i || (w_wr_fire && bus.wr_last_i)) w_next_state = c_FILL;
         c_EARLY: w_next_state = bus.wr_abort_i ? c_FILL : c_SEND;
         c_SEND:  if (bus.wr_abort_i || (bus.app_ready_v_i && w_last_rd)) w_next_state = c_FILL;
         default: w_next_state = c_FILL;
      endcase
   end

   // Outputs decoded from state; announce fields read zero outside EARLY/SEND.
   always_comb begin
      bus.wr_ready_o    = (r_state == c_FILL) | (r_state == c_DROP);
      bus.drop_o        = ~bus.wr_abort_i & w_wr_fire & bus.wr_last_i
                        & ((r_state == c_DROP) | ((r_state == c_FILL) & w_full));
      bus.app_early_v_o = (r_state == c_EARLY);
      bus.app_cancel_o  = bus.wr_abort_i & w_busy;
      bus.app_valid_o   = (r_state == c_SEND);
      bus.app_data_o    = (r_state == c_SEND) ? r_rd_data : '0;
      bus.app_len_o     = (r_state == c_SEND) ? r_rd_len  : '0;
      bus.app_pkt_len_o = w_busy ? r_pkt_len : '0;
      bus.app_cs_o      = w_busy ? w_pkt_cs  : '0;
   end

   // Pointer, length and beat-count bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_len_acc  <= '0;
         r_beat_cnt <= '0;
         r_pkt_len  <= '0;
      end else if (w_clear) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_len_acc <= '0;
      end else if (w_store) begin
         if (!w_full) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_len_acc <= w_len_next;
         if (bus.wr_last_i) begin
            r_beat_cnt <= r_wr_ptr + PTR_W'(1);
            r_pkt_len  <= w_len_next;
         end
      end else if ((r_state == c_SEND) && bus.app_ready_v_i) begin
         r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Beat storage with registered read.
   always_ff @(posedge clk) begin
      if (w_store && !w_full) begin
         r_mem[ADDR_W'(r_wr_ptr)]     <= bus.wr_data_i;
         r_len_mem[ADDR_W'(r_wr_ptr)] <= bus.wr_len_i;
      end
      r_rd_data <= r_mem[w_rd_addr];
      r_rd_len  <= r_len_mem[w_rd_addr];
   end

`ifdef ETH_TX_PKT_BUF_CS_EN
   logic [15:0] r_cs_acc, r_pkt_cs, w_cs_next;
   logic [31:0] w_cs_sum;
   logic [16:0] w_cs_f1;

   // Add this beat's big-endian words (invalid bytes zeroed) and fold carries.
   always_comb begin
      w_cs_sum = {16'd0, r_cs_acc};
      for (int w = 0; w < KEEP_W / 2; w++) begin
         w_cs_sum = w_cs_sum + {16'd0,
            ((2 * w)     < int'(bus.wr_len_i)) ? bus.wr_data_i[16*w +: 8]     : 8'h00,
            ((2 * w + 1) < int'(bus.wr_len_i)) ? bus.wr_data_i[16*w + 8 +: 8] : 8'h00};
      end
      w_cs_f1   = {1'b0, w_cs_sum[15:0]} + {1'b0, w_cs_sum[31:16]};
      w_cs_next = w_cs_f1[15:0] + {15'd0, w_cs_f1[16]};
   end

   // Running checksum and the value latched on the last beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cs_acc <= '0;
         r_pkt_cs <= '0;
      end else if (w_clear) begin
         r_cs_acc <= '0;
      end else if (w_store) begin
         r_cs_acc <= w_cs_next;
         if (bus.wr_last_i) r_pkt_cs <= w_cs_next;
      end
   end

   assign w_pkt_cs = r_pkt_cs;
`else
   assign w_pkt_cs = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_eth_tx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_tx_pkt_buf
// Description : Scoreboard bench for eth_tx_pkt_buf (DEPTH=4, 16-bit beats).
// Revision    : 1.0  initial release
// ============================================================================
module tb_eth_tx_pkt_buf;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 2;
   localparam int DEPTH  = 4;

   typedef logic [7:0] bq_t[$];
   typedef struct { int len; logic [15:0] cs; } pkt_t;
   typedef struct { logic [15:0] d; int l; bit last; } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   rnd_ready = 1'b0;
   int   n_chk = 0, n_pass = 0;
   pkt_t  q_pkt[$];
   beat_t q_beat[$];
   int    q_drop[$];

   eth_tx_pkt_buf_if #(.DATA_W(DATA_W), .PKT_LEN_W(16), .UDP_CS_W(16)) bus ();

   eth_tx_pkt_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: length = byte count, checksum = folded sum of big-endian word pairs.
   task automatic model_push(input bq_t b);
      int n = b.size();
      int nb = (n == 0) ? 1 : (n + 1) / 2;
      longint s = 0;
      pkt_t p;
      beat_t bt;
      if (nb > DEPTH) begin
         q_drop.push_back(n);
         return;
      end
      if (n == 0) return;
      for (int i = 0; i < n; i += 2)
         s += {b[i], (i + 1 < n) ? b[i+1] : 8'h00};
      while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
      p.len = n;
`ifdef ETH_TX_PKT_BUF_CS_EN
      p.cs = s[15:0];
`else
      p.cs = 16'h0000;
`endif
      q_pkt.push_back(p);
      for (int k = 0; k < nb; k++) begin
         bt.d    = {(2*k+1 < n) ? b[2*k+1] : 8'h00, b[2*k]};
         bt.l    = (n - 2*k >= 2) ? 2 : 1;
         bt.last = (k == nb - 1);
         q_beat.push_back(bt);
      end
   endtask

   task automatic send_pkt(input bq_t b);
      int n = b.size();
      int nb = (n == 0) ? 1 : (n + 1) / 2;
      int t;
      bit acc;
      model_push(b);
      for (int k = 0; k < nb; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.wr_valid_i = 1'b0;
            @(posedge clk); #1;
         end
         bus.wr_valid_i = 1'b1;
         bus.wr_data_i  = {(2*k+1 < n) ? b[2*k+1] : 8'h00, (2*k < n) ? b[2*k] : 8'h00};
         bus.wr_len_i   = LEN_W'((n - 2*k >= 2) ? 2 : ((n - 2*k == 1) ? 1 : 0));
         bus.wr_last_i  = (k == nb - 1);
         t = 0;
         do begin
            @(negedge clk); acc = bus.wr_ready_o;
            @(posedge clk); #1; t++;
         end while (!acc && t < 1000);
         if (!acc) chk(1'b0, "wr_accept_timeout", 0, 1);
      end
      bus.wr_valid_i = 1'b0;
      bus.wr_last_i  = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((q_pkt.size() != 0 || q_beat.size() != 0 || q_drop.size() != 0) && t < 5000) begin
         @(posedge clk); t++;
      end
      if (t >= 5000) chk(1'b0, "drain_timeout", 32'(q_beat.size()), 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_valid();
      int t = 0;
      do begin @(negedge clk); t++; end while (!bus.app_valid_o && t < 100);
      chk(bus.app_valid_o, "valid_timeout", {31'd0, bus.app_valid_o}, 1);
   endtask

   // Random ready generator.
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rnd_ready) bus.app_ready_v_i = ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: pops expectations whenever the DUT presents something.
   initial begin
      pkt_t  p;
      beat_t e;
      logic [15:0] m;
      int cur_len = 0;
      bit prev_last = 0, prev_early = 0, prev_valid = 0, ready_next = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_last = 0; prev_early = 0; prev_valid = 0; ready_next = 0;
            continue;
         end
         if (ready_next) begin
            chk(bus.wr_ready_o, "ready_after_send", {31'd0, bus.wr_ready_o}, 1);
            ready_next = 0;
         end
         if (bus.app_early_v_o) begin
            chk(prev_last, "early_latency", {31'd0, prev_last}, 1);
            if (q_pkt.size() == 0) chk(1'b0, "unexpected_early", 1, 0);
            else begin
               p = q_pkt.pop_front();
               cur_len = p.len;
               chk(bus.app_pkt_len_o == 16'(p.len), "pkt_len", 32'(bus.app_pkt_len_o), 32'(p.len));
               chk(bus.app_cs_o == p.cs, "pkt_cs", 32'(bus.app_cs_o), 32'(p.cs));
            end
         end
         if (bus.app_valid_o) begin
            if (!prev_valid) chk(prev_early, "valid_latency", {31'd0, prev_early}, 1);
            chk(bus.app_pkt_len_o == 16'(cur_len), "pkt_len_hold", 32'(bus.app_pkt_len_o), 32'(cur_len));
            chk(!bus.wr_ready_o, "ready_low_in_send", {31'd0, bus.wr_ready_o}, 0);
            if (bus.app_ready_v_i) begin
               if (q_beat.size() == 0) chk(1'b0, "unexpected_beat", 32'(bus.app_data_o), 0);
               else begin
                  e = q_beat.pop_front();
                  m = (e.l == 2) ? 16'hFFFF : 16'h00FF;
                  chk((bus.app_data_o & m) == (e.d & m), "beat_data", 32'(bus.app_data_o & m), 32'(e.d & m));
                  chk(int'(bus.app_len_o) == e.l, "beat_len", 32'(bus.app_len_o), 32'(e.l));
                  if (e.last) ready_next = 1;
               end
            end
         end
         if (bus.drop_o) begin
            if (q_drop.size() == 0) chk(1'b0, "unexpected_drop", 1, 0);
            else begin
               void'(q_drop.pop_front());
               chk(bus.wr_last_i & bus.wr_valid_i, "drop_on_last", {31'd0, bus.wr_last_i}, 1);
            end
         end
         prev_last  = bus.wr_valid_i & bus.wr_ready_o & bus.wr_last_i & ~bus.wr_abort_i;
         prev_early = bus.app_early_v_o;
         prev_valid = bus.app_valid_o;
      end
   end

   initial begin
      bq_t b;
      int n;
      bus.wr_valid_i = 0; bus.wr_data_i = '0; bus.wr_len_i = '0;
      bus.wr_last_i = 0; bus.wr_abort_i = 0; bus.app_ready_v_i = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk(bus.wr_ready_o, "rst_wr_ready", {31'd0, bus.wr_ready_o}, 1);
      chk({bus.drop_o, bus.app_early_v_o, bus.app_cancel_o, bus.app_valid_o} == 4'b0,
          "rst_flags", {28'd0, bus.drop_o, bus.app_early_v_o, bus.app_cancel_o, bus.app_valid_o}, 0);
      chk(bus.app_pkt_len_o == 0 && bus.app_cs_o == 0 && bus.app_data_o == 0 && bus.app_len_o == 0,
          "rst_fields", {bus.app_pkt_len_o, bus.app_cs_o}, 0);
      @(posedge clk); #1;
      rnd_ready = 1;

      b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};       send_pkt(b);
      b = {8'hFF, 8'hFF, 8'h00, 8'h02};               send_pkt(b);
      b = {};                                          send_pkt(b);
      b = {};
      for (int i = 0; i < 12; i++) b.push_back(8'(i + 16));
      send_pkt(b);
      b = {8'h10, 8'h20, 8'h30};                      send_pkt(b);
      for (int p = 0; p < 40; p++) begin
         n = ($urandom_range(0, 9) == 0) ? 2 * $urandom_range(6, 8) : $urandom_range(0, 8);
         b = {};
         for (int i = 0; i < n; i++) b.push_back(8'($urandom));
         send_pkt(b);
      end
      drain();

      // Abort while the second beat is presented.
      rnd_ready = 0;
      @(posedge clk); #1 bus.app_ready_v_i = 0;
      b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; send_pkt(b);
      wait_valid();
      @(posedge clk); #1 bus.app_ready_v_i = 1;
      @(posedge clk); #1 bus.app_ready_v_i = 0; bus.wr_abort_i = 1;
      @(negedge clk);
      chk(bus.app_cancel_o, "cancel_pulse", {31'd0, bus.app_cancel_o}, 1);
      chk(bus.app_data_o == 16'h0403, "abort_beat2", 32'(bus.app_data_o), 32'h0403);
      @(posedge clk); #1 bus.wr_abort_i = 0;
      @(negedge clk);
      chk(!bus.app_cancel_o, "cancel_one_cycle", {31'd0, bus.app_cancel_o}, 0);
      chk(!bus.app_valid_o, "valid_after_abort", {31'd0, bus.app_valid_o}, 0);
      chk(bus.wr_ready_o, "ready_after_abort", {31'd0, bus.wr_ready_o}, 1);
      q_beat.delete();
      @(posedge clk); #1;

      // Asynchronous reset in the middle of replay.
      b = {8'hAA, 8'hBB, 8'hCC, 8'hDD}; send_pkt(b);
      wait_valid();
      @(posedge clk); #3 reset = 1'b1;
      #1;
      chk(!bus.app_valid_o && bus.wr_ready_o, "rst_mid_send", {30'd0, bus.app_valid_o, bus.wr_ready_o}, 1);
      chk(!bus.app_cancel_o && !bus.app_early_v_o && bus.app_pkt_len_o == 0 && bus.app_cs_o == 0,
          "rst_mid_fields", {bus.app_pkt_len_o, bus.app_cs_o}, 0);
      q_beat.delete();
      #2 reset = 1'b0;
      @(posedge clk); #1;
      rnd_ready = 1;
      b = {8'h11, 8'h22}; send_pkt(b);
      drain();

      chk(q_pkt.size() == 0 && q_beat.size() == 0 && q_drop.size() == 0, "queues_empty",
          32'(q_pkt.size() + q_beat.size() + q_drop.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/eth_tx_pkt_buf.md
# eth_tx_pkt_buf

Store-and-forward payload buffer directly upstream of the Ethernet TX pipe. It accepts one UDP payload from the application as a beat stream and computes the payload length and one's-complement checksum on the fly. Once the last beat is in, it announces the packet (early valid, length, checksum) and replays the stored beats into the TX pipe's data-streaming interface under its ready signal. It holds at most one packet at a time.

## Interface
Parameters:
- DATA_W, 16: beat width in bits; must be a multiple of 16.
- KEEP_W, DATA_W/8: bytes per beat.
- LEN_W, $clog2(KEEP_W+1): width of the per-beat byte count.
- PKT_LEN_W, 16: packet byte-length width.
- UDP_CS_W, 16: checksum width.
- DEPTH, 1024: buffer capacity in beats.
- ADDR_W, $clog2(DEPTH): buffer address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid_i  in  1  application beat valid.
- wr_data_i  in  DATA_W  beat data; byte 0 is [7:0].
- wr_len_i  in  LEN_W  valid bytes in the beat, from lane 0 upward; KEEP_W on every non-last beat.
- wr_last_i  in  1  last beat of the packet.
- wr_abort_i  in  1  discard the current packet.
- wr_ready_o  out  1  beat accepted when wr_valid_i & wr_ready_o.
- drop_o  out  1  one-cycle pulse: packet discarded on overflow.
- app_early_v_o  out  1  one-cycle packet announce to the TX pipe.
- app_pkt_len_o  out  PKT_LEN_W  payload byte count.
- app_cs_o  out  UDP_CS_W  payload one's-complement sum, not inverted.
- app_cancel_o  out  1  one-cycle cancel to the TX pipe.
- app_ready_v_i  in  1  TX pipe consumes the presented beat.
- app_valid_o  out  1  replay beat valid.
- app_data_o  out  DATA_W  replay data.
- app_len_o  out  LEN_W  replay byte count.

## Operation
States are FILL, DROP, EARLY and SEND. Reset enters FILL.

FILL:
- wr_ready_o=1.
- Each accepted beat is written at wr_ptr, wr_ptr increments, and len_acc += wr_len_i.
- On an accepted beat with wr_last_i:
  - if the total length including that beat is 0, the packet is silently discarded and the block stays in FILL;
  - otherwise the block latches beat count, length and checksum and goes to EARLY.
- On an accepted non-last beat while wr_ptr==DEPTH: go to DROP.

DROP:
- wr_ready_o=1; beats are swallowed and not stored.
- On an accepted wr_last_i: pulse drop_o, clear all counters, go to FILL.

EARLY:
- app_early_v_o=1 for exactly one cycle, then go to SEND.

SEND:
- app_valid_o=1 and beat rd_ptr is presented.
- While app_ready_v_i=1: rd_ptr advances by one per cycle with no bubble.
- While app_ready_v_i=0: the output holds.
- When the final beat is consumed: clear pointers and accumulators, go to FILL.

Abort:
- wr_abort_i in FILL or DROP: clear and stay in/return to FILL, with no drop_o.
- wr_abort_i in EARLY or SEND: pulse app_cancel_o, clear, go to FILL. An abort takes priority over same-cycle beat acceptance.

Holding and arithmetic:
- app_pkt_len_o and app_cs_o hold from EARLY through the end of SEND; they read 0 in FILL.
- len_acc is PKT_LEN_W bits; overflow is impossible because DEPTH*KEEP_W < 2^PKT_LEN_W is required.

Checksum:
- 16-bit words are {byte2i, byte2i+1} with the even byte in the MSB. Invalid bytes count as 0; an odd trailing byte is padded with 0x00.
- End-around carry is folded every beat.

## Timing
- Reset values: wr_ready_o=1; every other output is 0.
- From last beat accepted to app_early_v_o is 1 cycle.
- From EARLY to the first app_valid_o is 1 cycle.
- The buffer read is synchronous with a prefetched next address, so back-to-back app_ready_v_i gives 1 beat per cycle.
- After the final replay beat is consumed, wr_ready_o rises on the next cycle.
- wr_ready_o=0 in EARLY and SEND.
- Reset asserted mid-SEND ends the stream immediately and asynchronously; no app_cancel_o is issued.

## Configuration
- ETH_TX_PKT_BUF_CS_EN defined: checksum accumulation logic is present as described.
- ETH_TX_PKT_BUF_CS_EN undefined: no checksum logic is built and app_cs_o is tied to 0. This is used with TX pipes built without UDP checksum.

## Test plan
- 5-byte packet 01..05 (DATA_W=16: lens 2, 2, 1 last) -> app_early_v_o pulse 1 cycle after last; pkt_len=5; cs=0x0906; replays 0x0201, 0x0403, 0x??05 with lens 2, 2, 1.
- Same packet with app_ready_v_i toggling 1,0,0,1,1 -> beats hold while ready=0; no beat lost or duplicated; FILL the cycle after the third consumption.
- Bytes FF FF 00 02 -> cs=0x0002 (end-around carry).
- DEPTH=4, 6 full beats with last on beat 6 -> drop_o pulse on beat 6; no app_early_v_o; next packet handled normally.
- wr_abort_i while the second beat is presented in SEND -> app_cancel_o 1 cycle; app_valid_o=0 next cycle; wr_ready_o=1.
- Reset pulsed mid-SEND -> all outputs at reset values immediately; a fresh 2-byte packet then yields pkt_len=2.
